// File: rtl/trap_seq_pkg.sv
// Shared constants for the machine-mode trap/return sequencer: FSM encodings,
// CSR addresses, cause codes and mstatus field positions.
package trap_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_T_EPC    = 3'd1;
    localparam logic [2:0] ST_T_CAUSE  = 3'd2;
    localparam logic [2:0] ST_T_STATUS = 3'd3;
    localparam logic [2:0] ST_T_REDIR  = 3'd4;
    localparam logic [2:0] ST_R_STATUS = 3'd5;
    localparam logic [2:0] ST_R_REDIR  = 3'd6;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] CAUSE_ECALL_M   = 32'd11;
    localparam logic [31:0] CAUSE_IRQ_EXT_M = 32'h8000_000B;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Trap entry: stash MIE in MPIE, disable interrupts, record machine mode.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE] = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MIE] = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/trap_seq.sv
// Machine-mode trap/return sequencer that borrows the CSR file port from the pipeline.
// Define TRAP_SEQ_IRQ_EN to honour irq_req (gated by a shadow copy of mstatus.MIE).
module trap_seq
    import trap_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        ecall_req,
    input  logic        mret_req,
    input  logic        irq_req,
    input  logic [11:0] pipe_csr_addr,
    input  logic [31:0] pipe_csr_wdata,
    input  logic        pipe_csr_write,
    output logic [31:0] pipe_csr_rdata,
    output logic        pipe_stall,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        csr_write,
    input  logic [31:0] csr_rdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cause_q, cause_d;
    logic        take_irq;

`ifdef TRAP_SEQ_IRQ_EN
    logic mie_shadow_q, mie_shadow_d;

    assign take_irq = irq_req & mie_shadow_q;

    // Tracks mstatus.MIE by snooping every write that reaches the CSR file.
    always_comb begin
        mie_shadow_d = mie_shadow_q;
        if (csr_write && csr_addr == CSR_MSTATUS) begin
            mie_shadow_d = csr_wdata[MSTATUS_MIE];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_shadow_q <= 1'b0;
        end else begin
            mie_shadow_q <= mie_shadow_d;
        end
    end
`else
    logic unused_irq;

    assign unused_irq = irq_req;
    assign take_irq   = 1'b0;
`endif

    assign pipe_csr_rdata = csr_rdata;
    assign pipe_stall     = (state_q != ST_IDLE);

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        cause_d        = cause_q;
        csr_addr       = pipe_csr_addr;
        csr_wdata      = pipe_csr_wdata;
        csr_write      = pipe_csr_write;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (take_irq) begin
                    pc_d      = pc;
                    cause_d   = CAUSE_IRQ_EXT_M;
                    state_d   = ST_T_EPC;
                    csr_write = 1'b0;
                end else if (ecall_req) begin
                    pc_d      = pc;
                    cause_d   = CAUSE_ECALL_M;
                    state_d   = ST_T_EPC;
                    csr_write = 1'b0;
                end else if (mret_req) begin
                    pc_d      = pc;
                    state_d   = ST_R_STATUS;
                    csr_write = 1'b0;
                end
            end
            ST_T_EPC: begin
                csr_addr  = CSR_MEPC;
                csr_wdata = pc_q;
                csr_write = 1'b1;
                state_d   = ST_T_CAUSE;
            end
            ST_T_CAUSE: begin
                csr_addr  = CSR_MCAUSE;
                csr_wdata = cause_q;
                csr_write = 1'b1;
                state_d   = ST_T_STATUS;
            end
            ST_T_STATUS: begin
                csr_addr  = CSR_MSTATUS;
                csr_wdata = trap_mstatus(csr_rdata);
                csr_write = 1'b1;
                state_d   = ST_T_REDIR;
            end
            ST_T_REDIR: begin
                csr_addr       = CSR_MTVEC;
                csr_write      = 1'b0;
                redirect_valid = 1'b1;
                redirect_pc    = {csr_rdata[31:2], 2'b00};
                state_d        = ST_IDLE;
            end
            ST_R_STATUS: begin
                csr_addr  = CSR_MSTATUS;
                csr_wdata = mret_mstatus(csr_rdata);
                csr_write = 1'b1;
                state_d   = ST_R_REDIR;
            end
            ST_R_REDIR: begin
                csr_addr       = CSR_MEPC;
                csr_write      = 1'b0;
                redirect_valid = 1'b1;
                redirect_pc    = csr_rdata;
                state_d        = ST_IDLE;
            end
            default: begin
                csr_write = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        // A reset landing mid-sequence must not leave a half-finished write or redirect behind.
        if (rst) begin
            redirect_valid = 1'b0;
            redirect_pc    = 32'h0;
            if (state_q != ST_IDLE) begin
                csr_write = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= 32'h0;
            cause_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_trap_seq.sv
// Directed scoreboard bench for trap_seq: a behavioural CSR file sits behind the
// sequencer, and every CSR write and redirect is popped against queued expectations.
module tb_trap_seq;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] cyc;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        ecall_req;
    logic        mret_req;
    logic        irq_req;
    logic [11:0] pipe_csr_addr;
    logic [31:0] pipe_csr_wdata;
    logic        pipe_csr_write;
    logic [31:0] pipe_csr_rdata;
    logic        pipe_stall;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_write;
    logic [31:0] csr_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [31:0] m_mstatus = 32'h0;
    logic [31:0] m_mtvec   = 32'h0;
    logic [31:0] m_mepc    = 32'h0;
    logic [31:0] m_mcause  = 32'h0;

    wr_t exp_wr[$];
    rd_t exp_rd[$];
    wr_t w;
    rd_t r;

    int n_cmp = 0;
    int n_err = 0;
    int n_redir = 0;
    int cyc = 0;
    int redir_base;

    always #5 clk = ~clk;

    trap_seq dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .ecall_req      (ecall_req),
        .mret_req       (mret_req),
        .irq_req        (irq_req),
        .pipe_csr_addr  (pipe_csr_addr),
        .pipe_csr_wdata (pipe_csr_wdata),
        .pipe_csr_write (pipe_csr_write),
        .pipe_csr_rdata (pipe_csr_rdata),
        .pipe_stall     (pipe_stall),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_write      (csr_write),
        .csr_rdata      (csr_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Behavioural CSR register file: combinational read, write on the rising edge.
    always_comb begin
        case (csr_addr)
            12'h300: csr_rdata = m_mstatus;
            12'h305: csr_rdata = m_mtvec;
            12'h341: csr_rdata = m_mepc;
            12'h342: csr_rdata = m_mcause;
            default: csr_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (csr_write) begin
            case (csr_addr)
                12'h300: m_mstatus <= csr_wdata;
                12'h305: m_mtvec   <= csr_wdata;
                12'h341: m_mepc    <= csr_wdata;
                12'h342: m_mcause  <= csr_wdata;
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (csr_write) begin
            check("write_expected", {31'h0, (exp_wr.size() != 0)}, 32'h1);
            if (exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                check("csr_addr", {20'h0, csr_addr}, {20'h0, w.addr});
                check("csr_wdata", csr_wdata, w.data);
            end
        end
        if (redirect_valid) begin
            n_redir++;
            check("redirect_expected", {31'h0, (exp_rd.size() != 0)}, 32'h1);
            if (exp_rd.size() != 0) begin
                r = exp_rd.pop_front();
                check("redirect_pc", redirect_pc, r.pc);
                check("redirect_cycle", 32'(cyc), r.cyc);
            end
        end else begin
            check("redirect_pc_quiet", redirect_pc, 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe_write(input logic [11:0] a, input logic [31:0] d);
        pipe_csr_addr  = a;
        pipe_csr_wdata = d;
        pipe_csr_write = 1'b1;
        exp_wr.push_back('{addr: a, data: d});
        tick();
        pipe_csr_write = 1'b0;
        pipe_csr_addr  = 12'h0;
        pipe_csr_wdata = 32'h0;
    endtask

    // Called in the acceptance cycle: three CSR writes, redirect four cycles later.
    task automatic expect_trap(input logic [31:0] epc, input logic [31:0] cause,
                               input logic [31:0] status, input logic [31:0] target);
        exp_wr.push_back('{addr: 12'h341, data: epc});
        exp_wr.push_back('{addr: 12'h342, data: cause});
        exp_wr.push_back('{addr: 12'h300, data: status});
        exp_rd.push_back('{pc: target, cyc: 32'(cyc + 4)});
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_writes_left"}, 32'(exp_wr.size()), 32'h0);
        check({tag, "_redirects_left"}, 32'(exp_rd.size()), 32'h0);
    endtask

    initial begin
        rst            = 1'b1;
        pc             = 32'h0;
        ecall_req      = 1'b0;
        mret_req       = 1'b0;
        irq_req        = 1'b0;
        pipe_csr_addr  = 12'h0;
        pipe_csr_wdata = 32'h0;
        pipe_csr_write = 1'b0;

        tick();
        tick();
        check("reset_stall", {31'h0, pipe_stall}, 32'h0);
        check("reset_redirect_valid", {31'h0, redirect_valid}, 32'h0);
        check("reset_redirect_pc", redirect_pc, 32'h0);
        rst = 1'b0;
        tick();
        check("idle_stall", {31'h0, pipe_stall}, 32'h0);

        // Pipeline pass-through sets up mtvec and mstatus (MIE=1).
        pipe_write(12'h305, 32'h8000_1003);
        pipe_write(12'h300, 32'h0000_0008);
        pipe_csr_addr = 12'h305;
        #1;
        check("pipe_rdata_mtvec", pipe_csr_rdata, 32'h8000_1003);
        pipe_csr_addr = 12'h0;

        // ECALL: mepc, mcause=11, mstatus 0x8 -> 0x1880, redirect to aligned mtvec.
        pc = 32'h8000_0100;
        ecall_req = 1'b1;
        expect_trap(32'h8000_0100, 32'd11, 32'h0000_1880, 32'h8000_1000);
        tick();
        ecall_req = 1'b0;
        check("ecall_stall", {31'h0, pipe_stall}, 32'h1);
        repeat (5) tick();
        check_drained("ecall");
        check("ecall_stall_done", {31'h0, pipe_stall}, 32'h0);

        // MRET: mstatus 0x1880 -> 0x1888, redirect to mepc two cycles later.
        pipe_write(12'h341, 32'h8000_0104);
        pc = 32'h8000_0050;
        mret_req = 1'b1;
        exp_wr.push_back('{addr: 12'h300, data: 32'h0000_1888});
        exp_rd.push_back('{pc: 32'h8000_0104, cyc: 32'(cyc + 2)});
        tick();
        mret_req = 1'b0;
        check("mret_stall", {31'h0, pipe_stall}, 32'h1);
        repeat (3) tick();
        check_drained("mret");

        // ECALL + MRET + pipeline mtvec write together: ecall wins, the write is dropped.
        pc = 32'h8000_0200;
        ecall_req = 1'b1;
        mret_req = 1'b1;
        pipe_csr_addr = 12'h305;
        pipe_csr_wdata = 32'hDEAD_BEEF;
        pipe_csr_write = 1'b1;
        expect_trap(32'h8000_0200, 32'd11, 32'h0000_1880, 32'h8000_1000);
        tick();
        ecall_req = 1'b0;
        mret_req = 1'b0;
        pipe_csr_write = 1'b0;
        pipe_csr_addr = 12'h0;
        pipe_csr_wdata = 32'h0;
        repeat (5) tick();
        check_drained("collide");
        check("collide_mtvec", m_mtvec, 32'h8000_1003);

        // ECALL pulsed again while in T_STATUS must be ignored.
        redir_base = n_redir;
        pc = 32'h8000_0300;
        ecall_req = 1'b1;
        expect_trap(32'h8000_0300, 32'd11, 32'h0000_1800, 32'h8000_1000);
        tick();
        ecall_req = 1'b0;
        tick();
        tick();
        ecall_req = 1'b1;
        tick();
        ecall_req = 1'b0;
        repeat (5) tick();
        check_drained("busy_ecall");
        check("busy_ecall_redirects", 32'(n_redir - redir_base), 32'h1);

        // Reset during T_CAUSE: only mepc lands, no mstatus write, no redirect.
        redir_base = n_redir;
        pc = 32'h8000_0400;
        ecall_req = 1'b1;
        exp_wr.push_back('{addr: 12'h341, data: 32'h8000_0400});
        tick();
        ecall_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_stall", {31'h0, pipe_stall}, 32'h0);
        rst = 1'b0;
        repeat (6) tick();
        check("rst_mid_redirects", 32'(n_redir - redir_base), 32'h0);
        check("rst_mid_mstatus", m_mstatus, 32'h0000_1800);
        check_drained("rst_mid");

`ifdef TRAP_SEQ_IRQ_EN
        // Level IRQ with MIE=1 traps once; the trap clears MIE so the held level is then ignored.
        pipe_write(12'h300, 32'h0000_1808);
        pc = 32'h8000_0500;
        irq_req = 1'b1;
        expect_trap(32'h8000_0500, 32'h8000_000B, 32'h0000_1880, 32'h8000_1000);
        tick();
        check("irq_stall", {31'h0, pipe_stall}, 32'h1);
        repeat (8) tick();
        irq_req = 1'b0;
        check("irq_stall_done", {31'h0, pipe_stall}, 32'h0);
        check_drained("irq");
        check("irq_mcause", m_mcause, 32'h8000_000B);
`else
        // Without interrupt support irq_req has no effect even with MIE=1.
        pipe_write(12'h300, 32'h0000_1808);
        pc = 32'h8000_0500;
        irq_req = 1'b1;
        repeat (4) begin
            tick();
            check("irq_ignored_stall", {31'h0, pipe_stall}, 32'h0);
        end
        irq_req = 1'b0;
        tick();
        check_drained("irq_ignored");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trap_seq.md
TRAP_SEQ -- requirements
Module: trap_seq

Interface
REQ-001 SHALL have clock and reset ports: one clock; reset is synchronous and active-high.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: pc  input  32  PC of the instruction raising the request.
REQ-005 SHALL have port: ecall_req  input  1  ECALL retiring this cycle.
REQ-006 SHALL have port: mret_req  input  1  MRET retiring this cycle.
REQ-007 SHALL have port: irq_req  input  1  level machine external interrupt.
REQ-008 SHALL have port: pipe_csr_addr  input  12  pipeline CSR address.
REQ-009 SHALL have port: pipe_csr_wdata  input  32  pipeline CSR write data.
REQ-010 SHALL have port: pipe_csr_write  input  1  pipeline CSR write enable.
REQ-011 SHALL have port: pipe_csr_rdata  output  32  CSR read data to pipeline; equals csr_rdata.
REQ-012 SHALL have port: pipe_stall  output  1  high whenever the sequencer is not IDLE.
REQ-013 SHALL have port: csr_addr  output  12  CSR register file address.
REQ-014 SHALL have port: csr_wdata  output  32  CSR register file write data.
REQ-015 SHALL have port: csr_write  output  1  CSR register file write enable.
REQ-016 SHALL have port: csr_rdata  input  32  combinational read data from the CSR register file.
REQ-017 SHALL have port: redirect_valid  output  1  one-cycle PC redirect strobe.
REQ-018 SHALL have port: redirect_pc  output  32  redirect target, valid with redirect_valid.

Function
REQ-019 SHALL implement FSM states IDLE, T_EPC, T_CAUSE, T_STATUS, T_REDIR, R_STATUS and R_REDIR.
REQ-020 IDLE SHALL pass pipe_csr_addr, pipe_csr_wdata and pipe_csr_write through to csr_addr, csr_wdata and csr_write.
REQ-021 IDLE SHALL apply request priority irq (gated by mie_shadow) > ecall > mret; the winner SHALL latch pc and cause and move to T_EPC or R_STATUS.
REQ-022 A request accepted in IDLE SHALL force csr_write=0 that cycle, suppressing any pipeline write.
REQ-023 T_EPC SHALL drive csr_addr=0x341, wdata=latched pc, write=1.
REQ-024 T_CAUSE SHALL drive csr_addr=0x342, write=1, wdata=11 for ecall and 0x8000000B for irq.
REQ-025 T_STATUS SHALL drive csr_addr=0x300, write=1, wdata=csr_rdata with bit7(MPIE)=bit3, bit3(MIE)=0, bits12:11(MPP)=2'b11.
REQ-026 T_REDIR SHALL drive csr_addr=0x305, write=0; redirect_valid=1, redirect_pc={csr_rdata[31:2],2'b00}; next state IDLE.
REQ-027 R_STATUS SHALL drive csr_addr=0x300, write=1, wdata=csr_rdata with bit3=bit7 and bit7=1.
REQ-028 R_REDIR SHALL drive csr_addr=0x341, write=0; redirect_valid=1, redirect_pc=csr_rdata; next state IDLE.
REQ-029 Latency SHALL be: trap redirect in the 4th cycle after acceptance; mret redirect in the 2nd cycle after acceptance.
REQ-030 Requests arriving while not IDLE SHALL be ignored; irq is level and re-samples in IDLE.
REQ-031 mie_shadow SHALL be updated on every csr_write to 0x300 with wdata bit3, whatever the source.
REQ-032 pipe_stall SHALL be high in every non-IDLE state.
REQ-033 Outside T_REDIR and R_REDIR, redirect_valid SHALL be 0 and redirect_pc SHALL be 0.

Reset
REQ-034 rst SHALL set state=IDLE, mie_shadow=0, latched pc/cause=0, redirect_valid=0, redirect_pc=0 and pipe_stall=0.
REQ-035 rst mid-sequence SHALL abandon the sequence next edge with no further CSR write and no redirect.

Configuration
REQ-036 With TRAP_SEQ_IRQ_EN defined, irq_req SHALL be honoured per REQ-021.
REQ-037 Without TRAP_SEQ_IRQ_EN, irq_req SHALL be ignored and mie_shadow logic SHALL be omitted; ecall/mret behaviour SHALL be unchanged.

Structure
REQ-038 Shared package trap_pkg SHALL hold the FSM state enum, CSR addresses (0x300, 0x305, 0x341, 0x342), cause codes and mstatus bit indices (MIE=3, MPIE=7, MPP=12:11).
REQ-039 The block SHALL be a single module with no sub-module; the next-state and output-mux logic is a single FSM.

Verification
REQ-040 Scenario: mtvec=0x80001003, ecall_req at pc=0x80000100 -> writes mepc=0x80000100, mcause=11, mstatus MIE=0/MPP=3; redirect_pc=0x80001000 on cycle 4.
REQ-041 Scenario: mepc=0x80000104, mstatus=0x1880, mret_req -> mstatus written 0x1888; redirect_pc=0x80000104 on cycle 2.
REQ-042 Scenario: ecall_req, mret_req and pipe_csr_write to 0x305 in the same IDLE cycle -> ecall sequence runs; the pipeline write is suppressed and mtvec is unchanged.
REQ-043 Scenario: TRAP_SEQ_IRQ_EN defined, pipeline writes mstatus=0x1808, then irq_req -> mcause=0x8000000B; irq with MIE=0 -> no trap.
REQ-044 Scenario: rst asserted in T_CAUSE -> state IDLE next cycle, no mstatus write, redirect_valid never asserted.
REQ-045 Scenario: ecall_req pulsed while in T_STATUS -> ignored; exactly one redirect occurs.
